// File: rtl/shift_reg_sequencer_if.sv
// Command/drive bundle between a command source and shift_reg_sequencer:
// valid/ready command fields in, shift-register drive and status out.
interface shift_reg_sequencer_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_lin;
  logic             cmd_rin;
  logic [2:0]       sel;
  logic [WIDTH-1:0] data;
  logic             lin;
  logic             rin;
  logic             busy;
  logic             done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_lin, cmd_rin,
    output cmd_ready, sel, data, lin, rin, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_lin, cmd_rin,
    input  cmd_ready, sel, data, lin, rin, busy, done
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Command sequencer that drives a universal shift register for N cycles per command.
// Define SHSEQ_FIFO_EN to place a DEPTH-entry command FIFO in front of the FSM.
module shift_reg_sequencer #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  clr,
  shift_reg_sequencer_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_EXEC  = 1'b1;
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_bad
    $error("shift_reg_sequencer: DEPTH must be a power of 2 and at least 2");
  end

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_data;
  logic             r_lin;
  logic             r_rin;
  logic             r_busy;
  logic             r_done;

  logic             w_slot_free;
  logic             w_ready;
  logic             w_start;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_data;
  logic [CNT_W-1:0] w_cnt;
  logic             w_lin;
  logic             w_rin;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_last;

  // The counter reads 0 in IDLE and during the final execute cycle, so either
  // condition lets the next command start on this edge without a gap.
  assign w_last      = (r_state == S_EXEC) && (r_cnt == {CNT_W{1'b0}});
  assign w_slot_free = (r_state == S_IDLE) || (r_cnt == {CNT_W{1'b0}});

`ifdef SHSEQ_FIFO_EN
  localparam int AW    = $clog2(DEPTH);
  localparam int CMD_W = 3 + WIDTH + CNT_W + 2;

  logic [CMD_W-1:0] r_fifo [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_ready = !clr && !w_full;
  assign w_push  = bus.cmd_valid && w_ready;
  assign w_pop   = !clr && w_slot_free && !w_empty;
  assign w_start = w_pop;
  assign {w_op, w_data, w_cnt, w_lin, w_rin} = r_fifo[r_rptr[AW-1:0]];

  // FIFO storage write; contents need no reset because the pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr[AW-1:0]] <= {bus.cmd_op, bus.cmd_data, bus.cmd_cnt, bus.cmd_lin, bus.cmd_rin};
    end
  end

  // FIFO pointers; clr flushes every queued command
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wptr <= {(AW + 1){1'b0}};
      r_rptr <= {(AW + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW + 1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW + 1)'(1);
      end
    end
  end
`else
  assign w_ready = !clr && w_slot_free;
  assign w_start = bus.cmd_valid && w_ready;
  assign w_op    = bus.cmd_op;
  assign w_data  = bus.cmd_data;
  assign w_cnt   = bus.cmd_cnt;
  assign w_lin   = bus.cmd_lin;
  assign w_rin   = bus.cmd_rin;
`endif

  // Execute length minus one: hold/load run once, a zero count is treated as one
  always_comb begin
    w_len_m1 = {CNT_W{1'b0}};
    if (w_op == OP_HOLD || w_op == OP_LOAD) begin
      w_len_m1 = {CNT_W{1'b0}};
    end else if (w_cnt == {CNT_W{1'b0}}) begin
      w_len_m1 = {CNT_W{1'b0}};
    end else begin
      w_len_m1 = w_cnt - CNT_W'(1);
    end
  end

  // Sequencer FSM and registered shift-register drive
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_sel   <= OP_HOLD;
      r_data  <= {WIDTH{1'b0}};
      r_lin   <= 1'b0;
      r_rin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_state <= S_EXEC;
        r_cnt   <= w_len_m1;
        r_sel   <= w_op;
        r_data  <= w_data;
        r_lin   <= w_lin;
        r_rin   <= w_rin;
        r_busy  <= 1'b1;
      end else if (r_state == S_EXEC) begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          r_state <= S_IDLE;
          r_sel   <= OP_HOLD;
          r_busy  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end else begin
        r_sel  <= OP_HOLD;
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.sel       = r_sel;
  assign bus.data      = r_data;
  assign bus.lin       = r_lin;
  assign bus.rin       = r_rin;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural shift register on its outputs.
module tb_shift_reg_sequencer;
  localparam int WIDTH = 3;
  localparam int CNT_W = 3;
  localparam int DEPTH = 4;
`ifdef SHSEQ_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       clr;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] m_out;

  shift_reg_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Universal shift register fed by the sequencer outputs
  always @(posedge clk) begin
    case (bus.sel)
      3'b001:  m_out <= bus.data;
      3'b010:  m_out <= {bus.rin, m_out[2:1]};
      3'b011:  m_out <= {m_out[1:0], bus.lin};
      3'b100:  m_out <= {1'b0, m_out[2:1]};
      3'b101:  m_out <= {m_out[1:0], 1'b0};
      3'b110:  m_out <= {m_out[0], m_out[2:1]};
      3'b111:  m_out <= {m_out[1:0], m_out[2]};
      default: m_out <= m_out;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command and hold it until it is accepted; returns 1 time unit after the accept edge
  task automatic send(input logic [2:0] op, input logic [2:0] dat, input logic [2:0] cnt,
                      input logic l, input logic r);
    logic rdy;
    rdy = 1'b0;
    bus.cmd_op    = op;
    bus.cmd_data  = dat;
    bus.cmd_cnt   = cnt;
    bus.cmd_lin   = l;
    bus.cmd_rin   = r;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
    end
    bus.cmd_valid = 1'b0;
    chk("accept", {7'd0, rdy}, 8'd1);
  endtask

`ifdef SHSEQ_FIFO_EN
  logic [2:0] exp_sel [8];
  logic       exp_done [8];
`endif

  initial begin
    clr           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b001;
    bus.cmd_data  = 3'b111;
    bus.cmd_cnt   = 3'd0;
    bus.cmd_lin   = 1'b1;
    bus.cmd_rin   = 1'b1;
    #1;
    chk("rst_ready", {7'd0, bus.cmd_ready}, 8'd0);
    tick();
    tick();
    chk("rst_sel", {5'd0, bus.sel}, 8'd0);
    chk("rst_data", {5'd0, bus.data}, 8'd0);
    chk("rst_lin", {7'd0, bus.lin}, 8'd0);
    chk("rst_rin", {7'd0, bus.rin}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_done", {7'd0, bus.done}, 8'd0);
    clr           = 1'b0;
    bus.cmd_valid = 1'b0;
    tick();
    chk("rst_noacc_sel", {5'd0, bus.sel}, 8'd0);
    chk("rst_noacc_busy", {7'd0, bus.busy}, 8'd0);

    // Single-cycle load of 101
    send(3'b001, 3'b101, 3'd0, 1'b0, 1'b0);
    repeat (LAT - 1) tick();
    chk("ld_sel", {5'd0, bus.sel}, 8'h01);
    chk("ld_data", {5'd0, bus.data}, 8'h05);
    chk("ld_busy", {7'd0, bus.busy}, 8'd1);
    chk("ld_done0", {7'd0, bus.done}, 8'd0);
    tick();
    chk("ld_sel_idle", {5'd0, bus.sel}, 8'd0);
    chk("ld_busy_idle", {7'd0, bus.busy}, 8'd0);
    chk("ld_done", {7'd0, bus.done}, 8'd1);
    chk("ld_model", {5'd0, m_out}, 8'h05);
    tick();
    chk("ld_done_clear", {7'd0, bus.done}, 8'd0);
    chk("ld_data_hold", {5'd0, bus.data}, 8'h05);

    // Load 001 then rotate left three times
    send(3'b001, 3'b001, 3'd0, 1'b0, 1'b0);
    repeat (LAT - 1) tick();
    tick();
    tick();
    chk("rol_pre_model", {5'd0, m_out}, 8'h01);
    send(3'b111, 3'b110, 3'd3, 1'b0, 1'b0);
    repeat (LAT - 1) tick();
    chk("rol_c1_sel", {5'd0, bus.sel}, 8'h07);
    chk("rol_c1_busy", {7'd0, bus.busy}, 8'd1);
    chk("rol_c1_data", {5'd0, bus.data}, 8'h06);
    tick();
    chk("rol_c2_sel", {5'd0, bus.sel}, 8'h07);
    chk("rol_c2_model", {5'd0, m_out}, 8'h02);
    tick();
    chk("rol_c3_sel", {5'd0, bus.sel}, 8'h07);
    chk("rol_c3_model", {5'd0, m_out}, 8'h04);
    chk("rol_c3_done", {7'd0, bus.done}, 8'd0);
    tick();
    chk("rol_end_sel", {5'd0, bus.sel}, 8'd0);
    chk("rol_end_busy", {7'd0, bus.busy}, 8'd0);
    chk("rol_end_done", {7'd0, bus.done}, 8'd1);
    chk("rol_end_model", {5'd0, m_out}, 8'h01);
    tick();
    chk("rol_done_clear", {7'd0, bus.done}, 8'd0);

`ifndef SHSEQ_FIFO_EN
    // Back-to-back: shift right fill 0 x2, then shift left fill lin=1 x1
    send(3'b100, 3'b000, 3'd2, 1'b0, 1'b0);
    chk("b2b_a1_sel", {5'd0, bus.sel}, 8'h04);
    bus.cmd_op    = 3'b011;
    bus.cmd_data  = 3'b000;
    bus.cmd_cnt   = 3'd1;
    bus.cmd_lin   = 1'b1;
    bus.cmd_rin   = 1'b0;
    bus.cmd_valid = 1'b1;
    #1;
    chk("b2b_ready_busy", {7'd0, bus.cmd_ready}, 8'd0);
    tick();
    chk("b2b_a2_sel", {5'd0, bus.sel}, 8'h04);
    chk("b2b_ready_last", {7'd0, bus.cmd_ready}, 8'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b2b_b1_sel", {5'd0, bus.sel}, 8'h03);
    chk("b2b_b1_lin", {7'd0, bus.lin}, 8'd1);
    chk("b2b_b1_busy", {7'd0, bus.busy}, 8'd1);
    chk("b2b_a_done", {7'd0, bus.done}, 8'd1);
    tick();
    chk("b2b_end_sel", {5'd0, bus.sel}, 8'd0);
    chk("b2b_b_done", {7'd0, bus.done}, 8'd1);
    chk("b2b_model", {5'd0, m_out}, 8'h01);

    // Zero count executes exactly once
    send(3'b101, 3'b000, 3'd0, 1'b0, 1'b0);
    chk("cnt0_sel", {5'd0, bus.sel}, 8'h05);
    chk("cnt0_done_prev", {7'd0, bus.done}, 8'd0);
    tick();
    chk("cnt0_end_sel", {5'd0, bus.sel}, 8'd0);
    chk("cnt0_done", {7'd0, bus.done}, 8'd1);
    tick();
`endif

    // Reset in the third cycle of a seven-cycle rotate right
    send(3'b110, 3'b010, 3'd7, 1'b0, 1'b0);
    repeat (LAT - 1) tick();
    tick();
    tick();
    chk("mid_c3_sel", {5'd0, bus.sel}, 8'h06);
    clr           = 1'b1;
    bus.cmd_op    = 3'b001;
    bus.cmd_data  = 3'b111;
    bus.cmd_valid = 1'b1;
    #1;
    chk("mid_ready_clr", {7'd0, bus.cmd_ready}, 8'd0);
    tick();
    chk("mid_sel", {5'd0, bus.sel}, 8'd0);
    chk("mid_busy", {7'd0, bus.busy}, 8'd0);
    chk("mid_done", {7'd0, bus.done}, 8'd0);
    chk("mid_data", {5'd0, bus.data}, 8'd0);
    clr           = 1'b0;
    bus.cmd_valid = 1'b0;
    tick();
    chk("mid_after_sel", {5'd0, bus.sel}, 8'd0);
    chk("mid_after_busy", {7'd0, bus.busy}, 8'd0);
    chk("mid_after_done", {7'd0, bus.done}, 8'd0);

`ifdef SHSEQ_FIFO_EN
    // Fill the FIFO behind a seven-cycle command, then drain in order
    send(3'b101, 3'b000, 3'd7, 1'b0, 1'b0);
    send(3'b010, 3'b000, 3'd1, 1'b0, 1'b0);
    send(3'b011, 3'b000, 3'd1, 1'b0, 1'b0);
    send(3'b110, 3'b000, 3'd1, 1'b0, 1'b0);
    send(3'b111, 3'b000, 3'd1, 1'b0, 1'b0);
    bus.cmd_op    = 3'b001;
    bus.cmd_valid = 1'b1;
    #1;
    chk("fifo_full_ready", {7'd0, bus.cmd_ready}, 8'd0);
    bus.cmd_valid = 1'b0;
    exp_sel  = '{3'b101, 3'b101, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111, 3'b000};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fifo_sel_%0d", i), {5'd0, bus.sel}, {5'd0, exp_sel[i]});
      chk($sformatf("fifo_done_%0d", i), {7'd0, bus.done}, {7'd0, exp_done[i]});
    end

    // clr flushes queued commands
    send(3'b111, 3'b000, 3'd7, 1'b0, 1'b0);
    send(3'b010, 3'b000, 3'd1, 1'b0, 1'b0);
    send(3'b011, 3'b000, 3'd1, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("flush_busy_%0d", i), {7'd0, bus.busy}, 8'd0);
      chk($sformatf("flush_sel_%0d", i), {5'd0, bus.sel}, 8'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
Upstream command sequencer for the 3-bit universal shift register (shiftReg). It accepts operation commands over a valid/ready handshake and drives the register's sel/data/lin/rin inputs for the required number of clock cycles. Between commands it returns sel to hold. It reports busy and a one-cycle done pulse per command, so control logic can queue multi-cycle shift sequences without cycle-counting.

Parameters:
WIDTH, 3, data width driven to the shift register
CNT_W, 3, width of the repeat-count field
DEPTH, 4, command FIFO depth; used only when SHSEQ_FIFO_EN is defined; power of 2, at least 2

Ports:
clk  input  1  clock; all state updates on the rising edge
clr  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command this cycle
cmd_op  input  3  sel code to issue
cmd_data  input  WIDTH  load value, used when cmd_op=001
cmd_cnt  input  CNT_W  number of shift cycles; 0 is treated as 1
cmd_lin  input  1  lin value held for the whole command
cmd_rin  input  1  rin value held for the whole command
sel  output  3  to shiftReg sel; registered
data  output  WIDTH  to shiftReg data; registered
lin  output  1  to shiftReg lin; registered
rin  output  1  to shiftReg rin; registered
busy  output  1  high while a command is executing
done  output  1  one-cycle pulse after a command's last execute cycle

Behaviour:
- Op codes: 000 hold; 001 load; 010 shift right fill rin; 011 shift left fill lin; 100 shift right fill 0; 101 shift left fill 0; 110 rotate right; 111 rotate left.
- Execute length N: 1 for op 000 and op 001. Otherwise max(cmd_cnt,1). Maximum N = 2^CNT_W-1.
- Accept: cmd_valid && cmd_ready on a rising edge.
- FSM states: IDLE and EXEC.
  - IDLE -> EXEC on accept.
  - In EXEC, a down-counter loads N-1 and decrements each cycle.
  - When the counter is 0, EXEC -> IDLE, or EXEC -> EXEC if a new command is accepted or popped on the same edge.
- Outputs during execution: sel=op, data=cmd_data, lin=cmd_lin, rin=cmd_rin for exactly N consecutive cycles, starting the cycle after accept. busy=1 in the same cycles.
- Outputs in IDLE: sel=000. data, lin and rin hold their last values. busy=0.
- done: high for exactly one cycle, the cycle after a command's last execute cycle. This may coincide with the next command's first execute cycle.
- Back-to-back commands: no idle cycle between them. sel changes directly from the old op to the new op.
- cmd_ready (no FIFO): combinational. Equals !clr && (state==IDLE || (state==EXEC && counter==0)).
- Reset: while clr=1, on the clock edge:
  - sel=000, data=0, lin=0, rin=0, busy=0, done=0, counter=0, state=IDLE.
  - cmd_ready=0 while clr=1.
- Reset mid-command: execution aborts immediately, no done pulse, all queued commands are discarded.
- cmd_valid with cmd_ready=0: no effect. The source must hold the command until accepted.
- Counter width CNT_W. No wrap-around: a loaded value is at most 2^CNT_W-2.

Optional Feature:
SHSEQ_FIFO_EN
- Defined: a DEPTH-entry command FIFO sits in front of the FSM.
  - cmd_ready = !clr && !full.
  - The FSM pops when (IDLE || counter==0) and the FIFO is not empty.
  - Accept and pop in the same cycle are both performed.
  - Minimum latency from accept to first execute cycle is 2 cycles (1 FIFO write + 1 pop).
  - clr flushes the FIFO.
- Undefined: no FIFO. A single command is captured directly, with the cmd_ready rule above. Latency from accept to first execute cycle is 1 cycle.

Test Plan:
- Reset: clr=1 for 2 cycles with cmd_valid=1 -> cmd_ready=0, sel=000, data=000, busy=0, done=0. No command is accepted.
- Load: op=001, data=101 -> sel=001 and data=101 for 1 cycle, then done=1 for 1 cycle. sel=000 afterwards. A shiftReg model reads out=101.
- Multi-cycle shift: load 001, then op=111 with cnt=3 -> sel=111 for 3 cycles, busy high for 3 cycles, one done pulse. Model out: 010, 100, 001.
- Back-to-back: op=100 cnt=2 immediately followed by op=011 cnt=1 with lin=1 -> sel sequence 100,100,011 with no gap. done asserted twice. cnt=0 command executes 1 cycle.
- Reset mid-operation: op=110 with cnt=7, assert clr in the 3rd execute cycle -> next cycle sel=000 and busy=0. No done pulse. Queued commands are not executed.
- SHSEQ_FIFO_EN: push 4 commands while the first executes -> cmd_ready=0 when full. All 4 execute in order with no idle gap. 4 done pulses.
